// File: rtl/wb_core_rr_arbiter_if.sv
// Flattened Wishbone B3 bundle between NUM_MASTERS core buses, the arbiter and the shared slave port.
interface wb_core_rr_arbiter_if #(
  parameter int unsigned NUM_MASTERS = 2
);
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  logic [NUM_MASTERS*AW-1:0] m_adr_i;
  logic [NUM_MASTERS*DW-1:0] m_dat_i;
  logic [NUM_MASTERS*SW-1:0] m_sel_i;
  logic [NUM_MASTERS-1:0]    m_we_i;
  logic [NUM_MASTERS-1:0]    m_cyc_i;
  logic [NUM_MASTERS-1:0]    m_stb_i;
  logic [NUM_MASTERS*3-1:0]  m_cti_i;
  logic [NUM_MASTERS*2-1:0]  m_bte_i;
  logic [NUM_MASTERS*DW-1:0] m_dat_o;
  logic [NUM_MASTERS-1:0]    m_ack_o;
  logic [NUM_MASTERS-1:0]    m_err_o;
  logic [NUM_MASTERS-1:0]    m_rty_o;

  logic [AW-1:0] s_adr_o;
  logic [DW-1:0] s_dat_o;
  logic [SW-1:0] s_sel_o;
  logic          s_we_o;
  logic          s_cyc_o;
  logic          s_stb_o;
  logic [2:0]    s_cti_o;
  logic [1:0]    s_bte_o;
  logic [DW-1:0] s_dat_i;
  logic          s_ack_i;
  logic          s_err_i;
  logic          s_rty_i;

  // Arbiter view: slave to the cores, master toward the shared slave.
  modport slave (
    input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, m_cti_i, m_bte_i,
    input  s_dat_i, s_ack_i, s_err_i, s_rty_i,
    output m_dat_o, m_ack_o, m_err_o, m_rty_o,
    output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o
  );

  // Environment view: cores and shared slave surrounding the arbiter.
  modport master (
    output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, m_cti_i, m_bte_i,
    output s_dat_i, s_ack_i, s_err_i, s_rty_i,
    input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
    input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o
  );
endinterface

// File: rtl/wb_core_rr_arbiter.sv
// Round-robin Wishbone B3 arbiter: one core owns the shared slave for a whole cyc,
// with a response watchdog that errors out a transfer the slave never answers.
module wb_core_rr_arbiter #(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_ni,
  wb_core_rr_arbiter_if.slave    bus,
  output logic [NUM_MASTERS-1:0] grant_o,
  output logic                   timeout_o
);
  localparam int unsigned N        = NUM_MASTERS;
  localparam int unsigned IW       = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned WDW      = 16;
  localparam bit          WD_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [WDW-1:0] WD_LIMIT = (TIMEOUT_CYCLES == 0) ? '0 : WDW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t         r_state,   w_state_nxt;
  logic [N-1:0]   r_grant,   w_grant_nxt;
  logic [IW-1:0]  r_gidx,    w_gidx_nxt;
  logic [IW-1:0]  r_last,    w_last_nxt;
  logic [WDW-1:0] r_wd_cnt,  w_wd_cnt_nxt;
  logic           r_timeout, w_timeout_nxt;

  logic          w_pick_vld;
  logic [IW-1:0] w_pick;
  logic [IW:0]   w_scan;
  logic          w_g_cyc;
  logic          w_g_stb;
  logic          w_resp;
  logic          w_wd_fire;

  logic [31:0] w_adr [N];
  logic [31:0] w_dat [N];
  logic [3:0]  w_sel [N];
  logic [2:0]  w_cti [N];
  logic [1:0]  w_bte [N];

  // Per-master views of the flattened request vectors.
  for (genvar gi = 0; gi < N; gi++) begin : g_slice
    assign w_adr[gi] = bus.m_adr_i[gi*32 +: 32];
    assign w_dat[gi] = bus.m_dat_i[gi*32 +: 32];
    assign w_sel[gi] = bus.m_sel_i[gi*4 +: 4];
    assign w_cti[gi] = bus.m_cti_i[gi*3 +: 3];
    assign w_bte[gi] = bus.m_bte_i[gi*2 +: 2];
  end

  assign bus.m_dat_o = {N{bus.s_dat_i}};
  assign grant_o     = r_grant;
  assign timeout_o   = r_timeout;

  // (base + off) mod N without a divider; off never exceeds N.
  function automatic logic [IW:0] wrap_idx(input logic [IW-1:0] base, input int unsigned off);
    logic [IW:0] sum;
    sum = {1'b0, base} + (IW+1)'(off);
    if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
    return sum;
  endfunction

  // First requester after the previous owner, wrapping around.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick     = '0;
    w_scan     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_scan = wrap_idx(r_last, k + 1);
      if (!w_pick_vld && bus.m_cyc_i[w_scan[IW-1:0]]) begin
        w_pick_vld = 1'b1;
        w_pick     = w_scan[IW-1:0];
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_gidx    <= '0;
      r_last    <= IW'(N - 1);
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_gidx    <= w_gidx_nxt;
      r_last    <= w_last_nxt;
      r_wd_cnt  <= w_wd_cnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  // Next state plus the zero-latency slave/master muxing for the current owner.
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_gidx_nxt    = r_gidx;
    w_last_nxt    = r_last;
    w_wd_cnt_nxt  = '0;
    w_timeout_nxt = 1'b0;
    w_g_cyc       = 1'b0;
    w_g_stb       = 1'b0;
    w_resp        = 1'b0;
    w_wd_fire     = 1'b0;

    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    bus.s_sel_o = '0;
    bus.s_we_o  = 1'b0;
    bus.s_cyc_o = 1'b0;
    bus.s_stb_o = 1'b0;
    bus.s_cti_o = '0;
    bus.s_bte_o = '0;
    bus.m_ack_o = '0;
    bus.m_err_o = '0;
    bus.m_rty_o = '0;

    case (r_state)
      ST_IDLE: begin
        if (w_pick_vld) begin
          w_state_nxt = ST_BUSY;
          w_grant_nxt = N'(1) << w_pick;
          w_gidx_nxt  = w_pick;
        end
      end
      ST_BUSY: begin
        w_g_cyc   = bus.m_cyc_i[r_gidx];
        w_g_stb   = bus.m_stb_i[r_gidx];
        w_resp    = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;
        // An ack landing on the limit cycle wins over the forced err.
        w_wd_fire = WD_EN && w_g_stb && !w_resp && (r_wd_cnt == WD_LIMIT);

        bus.s_adr_o = w_adr[r_gidx];
        bus.s_dat_o = w_dat[r_gidx];
        bus.s_sel_o = w_sel[r_gidx];
        bus.s_we_o  = bus.m_we_i[r_gidx];
        bus.s_cyc_o = w_g_cyc;
        bus.s_stb_o = w_g_stb && !w_wd_fire;
        bus.s_cti_o = w_cti[r_gidx];
        bus.s_bte_o = w_bte[r_gidx];

        bus.m_ack_o[r_gidx] = bus.s_ack_i & w_g_cyc;
        bus.m_err_o[r_gidx] = (bus.s_err_i | w_wd_fire) & w_g_cyc;
        bus.m_rty_o[r_gidx] = bus.s_rty_i & w_g_cyc;

        if (WD_EN && w_g_stb && !w_resp && !w_wd_fire) w_wd_cnt_nxt = r_wd_cnt + WDW'(1);
        w_timeout_nxt = w_wd_fire;

        // Owner released: back to IDLE so the next owner waits one bus cycle.
        if (!w_g_cyc) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
          w_last_nxt  = r_gidx;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end
endmodule
